// File: rtl/port_ctrl_pkg.sv
// Shared types and helpers for the packed output-port controller.
package port_ctrl_pkg;

    // Controller states; HDR is only entered when the metadata header beat is enabled.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PACK,
        ST_DISCARD,
        ST_DRAIN,
        ST_META
    } state_e;

    // Widest beat the keep-mask helper can describe.
    localparam int MAX_LANES = 64;

    // Default packet limit and the byte-counter width it implies.
    localparam int DEFAULT_MAX_PKT_BYTES = 2048;
    localparam int DEFAULT_CNT_W         = $clog2(DEFAULT_MAX_PKT_BYTES + 1);

    // Byte-counter width able to hold the value max_bytes.
    function automatic int cnt_width(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // Lane count -> tkeep: the lowest 'lanes' bits set (3 -> ...0111).
    function automatic logic [MAX_LANES-1:0] keep_mask(input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < lanes);
        end
        return m;
    endfunction

endpackage

// File: rtl/port_byte_packer.sv
// Byte-to-beat packer: lane index, assembly register, output register with
// AXI-Stream hold semantics, and tkeep generation. The controller FSM decides
// when bytes are fed, when a header word is loaded and when state is flushed.
module port_byte_packer #(
    parameter int OUT_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   byte_en,
    input  logic [7:0]             byte_data,
    input  logic                   byte_last,
    input  logic                   hdr_load,
    input  logic [8*OUT_BYTES-1:0] hdr_data,
    input  logic                   out_ready,
    output logic                   out_free,
    output logic [8*OUT_BYTES-1:0] out_data,
    output logic [OUT_BYTES-1:0]   out_keep,
    output logic                   out_last,
    output logic                   out_valid
);
    import port_ctrl_pkg::*;

    localparam int IDX_W = $clog2(OUT_BYTES);

    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [OUT_BYTES-1:0][7:0]       asm_q, asm_d;
    logic [OUT_BYTES-1:0][7:0]       word;
    logic [8*OUT_BYTES-1:0]          data_q, data_d;
    logic [OUT_BYTES-1:0]            keep_q, keep_d;
    logic                            last_q, last_d;
    logic                            valid_q, valid_d;

    // The output register can take a new word when empty or being accepted now.
    assign out_free  = ~valid_q | out_ready;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_valid = valid_q;

    // Next-state for lane index, assembly word and output register.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        idx_d   = idx_q;
        asm_d   = asm_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q & ~out_ready;
        word    = asm_q;
        word[idx_q] = byte_data;

        if (flush) begin
            idx_d = '0;
            asm_d = '0;
        end else if (hdr_load) begin
            data_d  = hdr_data;
            keep_d  = '1;
            last_d  = 1'b0;
            valid_d = 1'b1;
        end else if (byte_en) begin
            if (byte_last || idx_q == IDX_W'(OUT_BYTES - 1)) begin
                // Unfilled upper lanes stay zero because asm is cleared after each emit.
                data_d  = word;
                keep_d  = OUT_BYTES'(keep_mask(int'(idx_q) + 1));
                last_d  = byte_last;
                valid_d = 1'b1;
                idx_d   = '0;
                asm_d   = '0;
            end else begin
                asm_d = word;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Packer registers; reset discards any partial word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            idx_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/packed_port_controller.sv
// Output-port controller: after a grant, drains one packet from the input byte
// buffer into OUT_BYTES-wide beats, truncates oversize packets, then consumes
// the packet's metadata word.
// Optional feature: define PORT_CTRL_META_HDR_EN to emit the metadata word as a
// header beat ahead of the packet data.
module packed_port_controller #(
    parameter int OUT_BYTES     = 4,
    parameter int META_W        = 32,
    parameter int MAX_PKT_BYTES = 2048
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   buf_axis_tvalid,
    input  logic [7:0]             buf_axis_tdata,
    input  logic                   buf_axis_tlast,
    output logic                   buf_axis_tready,
    input  logic                   meta_axis_tvalid,
    input  logic [META_W-1:0]      meta_axis_tdata,
    output logic                   meta_axis_tready,
    input  logic                   s_axis_tready,
    output logic [8*OUT_BYTES-1:0] s_axis_tdata,
    output logic [OUT_BYTES-1:0]   s_axis_tkeep,
    output logic                   s_axis_tlast,
    output logic                   s_axis_tvalid,
    input  logic                   start_transfer,
    output logic                   ready_transfer,
    output logic                   pkt_truncated
);
    import port_ctrl_pkg::*;

    localparam int DW    = 8 * OUT_BYTES;
    localparam int CNT_W = cnt_width(MAX_PKT_BYTES);

`ifdef PORT_CTRL_META_HDR_EN
    localparam state_e FIRST_STATE = ST_HDR;
`else
    localparam state_e FIRST_STATE = ST_PACK;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             trunc_q, trunc_d;

    logic             out_free;
    logic             flush;
    logic             byte_en;
    logic             byte_last;
    logic             hdr_load;
    logic             at_limit;
    logic [DW-1:0]    hdr_word;

    // Metadata truncated or zero-extended to one beat.
    assign hdr_word = DW'(meta_axis_tdata);

    // The byte being offered now would be byte number MAX_PKT_BYTES.
    assign at_limit = (cnt_q == CNT_W'(MAX_PKT_BYTES - 1));

    assign ready_transfer = ready_q;
    assign pkt_truncated  = trunc_q;

    // Controller next-state and handshake outputs.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        trunc_d          = 1'b0;
        buf_axis_tready  = 1'b0;
        meta_axis_tready = 1'b0;
        flush            = 1'b0;
        byte_en          = 1'b0;
        byte_last        = 1'b0;
        hdr_load         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                flush = 1'b1;
                cnt_d = '0;
                if (start_transfer) state_d = FIRST_STATE;
            end
            ST_HDR: begin
`ifdef PORT_CTRL_META_HDR_EN
                // Header peeks at the metadata; it is consumed later in META.
                if (meta_axis_tvalid && out_free) begin
                    hdr_load = 1'b1;
                    state_d  = ST_PACK;
                end
`else
                state_d = ST_PACK;
`endif
            end
            ST_PACK: begin
                buf_axis_tready = out_free;
                if (buf_axis_tvalid && out_free) begin
                    byte_en   = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    byte_last = buf_axis_tlast | at_limit;
                    if (buf_axis_tlast) begin
                        state_d = ST_DRAIN;
                    end else if (at_limit) begin
                        trunc_d = 1'b1;
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                buf_axis_tready = 1'b1;
                if (buf_axis_tvalid && buf_axis_tlast) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // The forced-tlast beat may already have left while discarding.
                if (!s_axis_tvalid || s_axis_tready) state_d = ST_META;
            end
            ST_META: begin
                meta_axis_tready = meta_axis_tvalid;
                if (meta_axis_tvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    // Controller registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            trunc_q <= trunc_d;
        end
    end

    port_byte_packer #(
        .OUT_BYTES (OUT_BYTES)
    ) u_packer (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .byte_en   (byte_en),
        .byte_data (buf_axis_tdata),
        .byte_last (byte_last),
        .hdr_load  (hdr_load),
        .hdr_data  (hdr_word),
        .out_ready (s_axis_tready),
        .out_free  (out_free),
        .out_data  (s_axis_tdata),
        .out_keep  (s_axis_tkeep),
        .out_last  (s_axis_tlast),
        .out_valid (s_axis_tvalid)
    );

endmodule

// File: tb/tb_packed_port_controller.sv
// Bench for packed_port_controller: packet-level reference model (expected beat
// queue built from packet contents), random source/sink timing, one monitor
// that compares every accepted beat and the hold/ready/truncation rules.
module tb_packed_port_controller;

    localparam int OB   = 4;
    localparam int MW   = 32;
    localparam int MAXB = 8;
    localparam int DW   = 8 * OB;
`ifdef PORT_CTRL_META_HDR_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [OB-1:0] keep;
        logic          last;
    } beat_t;

    logic          clk;
    logic          resetn;
    logic          buf_axis_tvalid;
    logic [7:0]    buf_axis_tdata;
    logic          buf_axis_tlast;
    logic          buf_axis_tready;
    logic          meta_axis_tvalid;
    logic [MW-1:0] meta_axis_tdata;
    logic          meta_axis_tready;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata;
    logic [OB-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          s_axis_tvalid;
    logic          start_transfer;
    logic          ready_transfer;
    logic          pkt_truncated;

    beat_t         exp_q[$];
    beat_t         got_q[$];
    logic [8:0]    in_q[$];
    logic [MW-1:0] meta_q[$];

    int n_checks;
    int n_pass;
    int meta_cnt;
    int trunc_cnt;
    int rdy_mode;

    packed_port_controller #(
        .OUT_BYTES     (OB),
        .META_W        (MW),
        .MAX_PKT_BYTES (MAXB)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .buf_axis_tvalid  (buf_axis_tvalid),
        .buf_axis_tdata   (buf_axis_tdata),
        .buf_axis_tlast   (buf_axis_tlast),
        .buf_axis_tready  (buf_axis_tready),
        .meta_axis_tvalid (meta_axis_tvalid),
        .meta_axis_tdata  (meta_axis_tdata),
        .meta_axis_tready (meta_axis_tready),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tkeep     (s_axis_tkeep),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tvalid    (s_axis_tvalid),
        .start_transfer   (start_transfer),
        .ready_transfer   (ready_transfer),
        .pkt_truncated    (pkt_truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Byte source: presents the head of in_q, holds it until accepted.
    initial begin : byte_drv
        logic hs;
        forever begin
            @(negedge clk);
            hs = buf_axis_tvalid & buf_axis_tready;
            @(posedge clk);
            #1;
            if (hs && in_q.size() > 0) void'(in_q.pop_front());
            if (in_q.size() == 0) buf_axis_tvalid = 1'b0;
            else if (!(buf_axis_tvalid && !hs)) buf_axis_tvalid = ($urandom_range(0, 3) != 0);
            {buf_axis_tlast, buf_axis_tdata} = (in_q.size() > 0) ? in_q[0] : 9'h0;
        end
    end

    // Metadata source.
    initial begin : meta_drv
        logic hs;
        forever begin
            @(negedge clk);
            hs = meta_axis_tvalid & meta_axis_tready;
            @(posedge clk);
            #1;
            if (hs && meta_q.size() > 0) void'(meta_q.pop_front());
            if (meta_q.size() == 0) meta_axis_tvalid = 1'b0;
            else if (!(meta_axis_tvalid && !hs)) meta_axis_tvalid = ($urandom_range(0, 2) != 0);
            meta_axis_tdata = (meta_q.size() > 0) ? meta_q[0] : '0;
        end
    end

    // Egress sink: always ready, random, 1-0-0-1 pattern, or stalled.
    initial begin : sink_drv
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k++;
            case (rdy_mode)
                0:       s_axis_tready = 1'b1;
                1:       s_axis_tready = 1'($urandom_range(0, 1));
                2:       s_axis_tready = (k % 4 == 0) || (k % 4 == 3);
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted beat against the model, plus hold and ready rules.
    initial begin : mon
        beat_t held;
        beat_t cur;
        beat_t e;
        logic  hold_pend;
        logic  meta_prev;
        logic  start_prev;
        hold_pend  = 1'b0;
        meta_prev  = 1'b0;
        start_prev = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold_pend  = 1'b0;
                meta_prev  = 1'b0;
                start_prev = 1'b0;
            end else begin
                cur.data = s_axis_tdata;
                cur.keep = s_axis_tkeep;
                cur.last = s_axis_tlast;
                if (hold_pend) begin
                    check("hold_valid", 64'(s_axis_tvalid), 64'd1);
                    check("hold_beat", 64'(cur), 64'(held));
                end
                if (meta_prev) check("ready_after_meta", 64'(ready_transfer), 64'd1);
                if (start_prev) check("ready_low_after_start", 64'(ready_transfer), 64'd0);
                if (s_axis_tvalid && s_axis_tready) begin
                    got_q.push_back(cur);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_beat: got data %0h with no beat expected", cur.data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(cur.data), 64'(e.data));
                        check("beat_keep", 64'(cur.keep), 64'(e.keep));
                        check("beat_last", 64'(cur.last), 64'(e.last));
                    end
                end
                hold_pend  = s_axis_tvalid && !s_axis_tready;
                held       = cur;
                if (pkt_truncated) trunc_cnt++;
                meta_prev  = meta_axis_tvalid && meta_axis_tready;
                if (meta_prev) meta_cnt++;
                start_prev = start_transfer && ready_transfer;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start_transfer = 1'b1;
        @(posedge clk);
        #1 start_transfer = 1'b0;
    endtask

    // Build the packet, its expected beats, and run it to completion.
    task automatic run_pkt(input int len, input bit seq, input logic [MW-1:0] meta);
        logic [7:0] bytes[$];
        beat_t      b;
        int         n;
        int         k;
        int         m0;
        int         t0;
        bit         done;
        for (int i = 0; i < len; i++) bytes.push_back(seq ? 8'(i + 1) : 8'($urandom));
        n = (len > MAXB) ? MAXB : len;
`ifdef PORT_CTRL_META_HDR_EN
        b.data = DW'(meta);
        b.keep = '1;
        b.last = 1'b0;
        exp_q.push_back(b);
`endif
        for (int s = 0; s < n; s += OB) begin
            b = '0;
            k = (n - s < OB) ? n - s : OB;
            for (int j = 0; j < k; j++) b.data[8*j +: 8] = bytes[s + j];
            b.keep = OB'((1 << k) - 1);
            b.last = (s + OB >= n);
            exp_q.push_back(b);
        end
        for (int i = 0; i < len; i++) in_q.push_back({(i == len - 1), bytes[i]});
        meta_q.push_back(meta);
        m0 = meta_cnt;
        t0 = trunc_cnt;
        pulse_start();
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (in_q.size() == 0) && (meta_q.size() == 0) && ready_transfer;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL pkt_timeout: len %0d not complete, %0d beats outstanding", len, exp_q.size());
            exp_q.delete();
            in_q.delete();
            meta_q.delete();
        end
        check("meta_once", 64'(meta_cnt - m0), 64'd1);
        check("trunc_pulses", 64'(trunc_cnt - t0), (len > MAXB) ? 64'd1 : 64'd0);
    endtask

    initial begin : main
        n_checks = 0; n_pass = 0; meta_cnt = 0; trunc_cnt = 0; rdy_mode = 0;
        resetn = 1'b0;
        buf_axis_tvalid = 1'b0; buf_axis_tdata = '0; buf_axis_tlast = 1'b0;
        meta_axis_tvalid = 1'b0; meta_axis_tdata = '0;
        s_axis_tready = 1'b1; start_transfer = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 64'(s_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(s_axis_tdata), 64'd0);
        check("rst_tkeep", 64'(s_axis_tkeep), 64'd0);
        check("rst_ready_transfer", 64'(ready_transfer), 64'd1);
        check("rst_trunc", 64'(pkt_truncated), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // 8-byte packet, sink always ready; exactly at the limit with real tlast.
        got_q.delete();
        run_pkt(8, 1'b1, 32'hA0000001);
        check("t1_nbeats", 64'(got_q.size()), 64'(H + 2));
        check("t1_beat0", 64'(got_q[H].data), 64'h04030201);
        check("t1_beat1", 64'(got_q[H + 1].data), 64'h08070605);
        check("t1_keep1", 64'(got_q[H + 1].keep), 64'hF);
        check("t1_last0", 64'(got_q[H].last), 64'd0);
        check("t1_last1", 64'(got_q[H + 1].last), 64'd1);

        // 5-byte packet: partial final beat.
        got_q.delete();
        run_pkt(5, 1'b1, 32'hA0000002);
        check("t2_keep0", 64'(got_q[H].keep), 64'hF);
        check("t2_keep1", 64'(got_q[H + 1].keep), 64'h1);
        check("t2_byte5", 64'(got_q[H + 1].data[7:0]), 64'h05);

        // Stalling sink 1-0-0-1.
        rdy_mode = 2;
        run_pkt(7, 1'b1, 32'hA0000003);

        // Oversize packet: 12 bytes against an 8-byte limit.
        rdy_mode = 0;
        got_q.delete();
        run_pkt(12, 1'b1, 32'hA0000004);
        check("t4_nbeats", 64'(got_q.size()), 64'(H + 2));
        check("t4_beat1", 64'(got_q[H + 1].data), 64'h08070605);
        check("t4_forced_last", 64'(got_q[H + 1].last), 64'd1);
        run_pkt(9, 1'b0, 32'hA0000005);
        run_pkt(1, 1'b0, 32'hA0000006);

        // Reset while mid-packet with the output register stalled.
        rdy_mode = 3;
        for (int i = 0; i < 10; i++) in_q.push_back({(i == 9), 8'(i + 1)});
        meta_q.push_back(32'hA0000007);
        pulse_start();
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_pkt_tvalid", 64'(s_axis_tvalid), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(s_axis_tvalid), 64'd0);
        check("arst_tdata", 64'(s_axis_tdata), 64'd0);
        check("arst_tkeep", 64'(s_axis_tkeep), 64'd0);
        check("arst_tlast", 64'(s_axis_tlast), 64'd0);
        check("arst_ready_transfer", 64'(ready_transfer), 64'd1);
        check("arst_buf_tready", 64'(buf_axis_tready), 64'd0);
        in_q.delete();
        meta_q.delete();
        exp_q.delete();
        rdy_mode = 0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(posedge clk);
        got_q.delete();
        run_pkt(6, 1'b1, 32'hA0000008);
        check("post_rst_beat0", 64'(got_q[H].data), 64'h04030201);
        check("post_rst_beat1", 64'(got_q[H + 1].data), 64'h00000605);

`ifdef PORT_CTRL_META_HDR_EN
        // Header beat carries the metadata word.
        got_q.delete();
        run_pkt(4, 1'b1, 32'hDEADBEEF);
        check("hdr_data", 64'(got_q[0].data), 64'hDEADBEEF);
        check("hdr_last", 64'(got_q[0].last), 64'd0);
        check("hdr_keep", 64'(got_q[0].keep), 64'hF);
        check("hdr_pay_last", 64'(got_q[1].last), 64'd1);
`endif

        // Random packets and sink timing.
        for (int p = 0; p < 40; p++) begin
            rdy_mode = $urandom_range(0, 2);
            run_pkt($urandom_range(1, 14), 1'b0, $urandom);
        end

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
